// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: active-low segment
// patterns (a..g in bits 0..6), anode idle value and digit slot encoding.
package ssd_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODES_OFF = 4'b1111;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment pattern; non-BCD
// codes (A..F) render as a dash.
import ssd_pkg::*;

module bcd_to_7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    unique case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/ssd_scan_driver.sv
// Basys 3 four-digit seven-segment scan driver with per-frame input snapshot.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
import ssd_pkg::*;

module ssd_scan_driver #(
  parameter int REFRESH_DIV  = 100_000,
  parameter int GUARD_CYCLES = 4
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] r_div_cnt;
  digit_t           r_digit;
  digit_t           w_digit_nxt;
  logic [15:0]      r_bcd_snap;
  logic [3:0]       r_dp_snap;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic             r_frame_tick;

  logic             w_slot_wrap;
  logic             w_frame_wrap;
  logic             w_active;
  logic             w_blank;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;

  bcd_to_7seg u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) r_digit <= DIG0;
    else       r_digit <= w_digit_nxt;
  end

  always_comb begin
    w_slot_wrap  = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));
    w_digit_nxt  = r_digit;
    w_frame_wrap = 1'b0;
    if (w_slot_wrap) begin
      unique case (r_digit)
        DIG0: w_digit_nxt = DIG1;
        DIG1: w_digit_nxt = DIG2;
        DIG2: w_digit_nxt = DIG3;
        DIG3: begin
          w_digit_nxt  = DIG0;
          w_frame_wrap = 1'b1;
        end
        default: w_digit_nxt = DIG0;
      endcase
    end
  end

  always_comb begin
    w_active = (32'(r_div_cnt) >= 32'(GUARD_CYCLES));
    w_nibble = r_bcd_snap[{r_digit, 2'b00} +: 4];
    w_blank  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    // A digit blanks only while every more-significant digit is also zero.
    unique case (r_digit)
      DIG3:    w_blank = (r_bcd_snap[15:12] == 4'd0);
      DIG2:    w_blank = (r_bcd_snap[15:8] == 8'd0);
      DIG1:    w_blank = (r_bcd_snap[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
`else
    w_blank  = 1'b0;
`endif
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_bcd_snap   <= '0;
      r_dp_snap    <= '0;
      r_frame_tick <= 1'b0;
      r_an         <= ANODES_OFF;
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b1;
    end else begin
      r_div_cnt    <= w_slot_wrap ? '0 : r_div_cnt + 1'b1;
      r_frame_tick <= w_frame_wrap;
      if (w_frame_wrap) begin
        r_bcd_snap <= bcd_in;
        r_dp_snap  <= dp_in;
      end
      r_an  <= w_active ? ~(4'b0001 << r_digit) : ANODES_OFF;
      r_seg <= w_blank ? SEG_BLANK : w_seg;
      r_dp  <= ~r_dp_snap[r_digit];
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule
